sort_bitonic_pipe: RTL and testbench
====================================

SORT_BITONIC_PIPE -- requirements
Module: sort_bitonic_pipe

Interface
REQ-001 SHALL have parameter N_ELEM, default 8, number of elements per vector; a power of two, at least 2.
REQ-002 SHALL have parameter W, default 8, unsigned element width in bits, at least 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input vector present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a vector this cycle.
REQ-007 SHALL have port in_data, input, N_ELEM*W, element i at bits [i*W +: W].
REQ-008 SHALL have port in_desc, input, 1, sort order per vector: 0 = ascending, 1 = descending.
REQ-009 SHALL have port out_valid, output, 1, sorted vector present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the vector.
REQ-011 SHALL have port out_data, output, N_ELEM*W, sorted elements, same packing as in_data.
REQ-012 SHALL have port out_idx, output, N_ELEM*log2(N_ELEM), out_idx element i = original input position of out_data element i.
REQ-013 SHALL have port busy, output, 1, high when any pipeline stage holds a valid vector.

Function
REQ-014 SHALL implement a bitonic network of S = L*(L+1)/2 compare-exchange stages, where L = log2(N_ELEM); S = 6 for N_ELEM = 8.
REQ-015 SHALL register every stage, so latency from the accept cycle (in_valid && in_ready) to first out_valid is exactly S cycles.
REQ-016 SHALL, in ascending mode, present element 0 as the minimum; in descending mode, element 0 as the maximum.
REQ-017 SHALL carry in_desc with each vector through the pipeline; vectors with different modes may be interleaved back-to-back.
REQ-018 SHALL swap in each comparator only when the compared keys are strictly out of order; equal keys keep their relative lane positions.
REQ-019 SHALL compare keys only; the index tags move with their keys and never affect ordering.
REQ-020 SHALL advance all stages together under one enable: en = !out_valid || out_ready.
REQ-021 SHALL drive in_ready = en, a combinational function of out_valid and out_ready.
REQ-022 SHALL, while en = 0, hold every stage register, out_data and out_idx stable.
REQ-023 SHALL sustain one vector per cycle when out_ready is held high.
REQ-024 SHALL insert a bubble (stage valid = 0) when en = 1 and in_valid = 0.
REQ-025 SHALL never drop or duplicate a vector.
REQ-026 SHALL complete an output transfer in any cycle where out_valid && out_ready.

Reset
REQ-027 SHALL, while rst = 1, clear every stage valid bit; one cycle after rst is sampled, out_valid = 0 and busy = 0.
REQ-028 SHALL leave data and index registers unreset; their contents are don't-care while their valid bit is 0.
REQ-029 SHALL discard all in-flight vectors on reset asserted mid-operation, and SHALL emit no stale output afterwards.
REQ-030 SHALL hold in_ready = 1 during and after reset, since out_valid = 0.

Structure
REQ-031 SHALL take its helpers from shared package sort_pkg: clog2 function, stage-count function S(N), and per-stage partner/direction functions.
REQ-032 SHALL build each comparator from one sub-module, sort_cmp_swap (parameter W, tag width; inputs a, b, tags, dir; outputs lo/hi with tags); all stages are generate-instantiated.

Verification (N_ELEM = 8, W = 8)
REQ-033 SHALL test ascending reverse order: in_data element i = 7-i, in_desc = 0 -> after 6 cycles, out_data element i = i and out_idx element i = 7-i.
REQ-034 SHALL test descending mode: in_data element i = i, in_desc = 1 -> out_data element i = 7-i; a second vector with in_desc = 0 on the next cycle -> ascending result one cycle later.
REQ-035 SHALL test streaming: 10 random distinct vectors back-to-back, out_ready = 1 -> 10 consecutive out_valid cycles starting 6 cycles after the first accept, each matching a reference sort.
REQ-036 SHALL test backpressure: out_ready low for 5 cycles mid-stream -> in_ready low in exactly those cycles where out_valid = 1, out_data stable, all vectors delivered once in order.
REQ-037 SHALL test extremes: all elements 0xFF -> output all 0xFF; elements {0x00, 0xFF} alternating -> four 0x00 then four 0xFF.
REQ-038 SHALL test reset mid-stream: rst pulsed with 3 vectors in flight -> out_valid = 0 and busy = 0 next cycle, and the first subsequent output is the first vector accepted after reset.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared helpers for the bitonic sorting pipeline: sizing functions
// and the per-stage wiring of the compare-exchange network.
package sort_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int n_stages(input int n);
        int l;
        l = clog2(n);
        return l * (l + 1) / 2;
    endfunction

    // Stage s belongs to merge block size 2^p and compares lanes 2^q apart.
    function automatic int stage_span(input int s, input int n,
                                      input bit want_block);
        int c;
        int r;
        c = 0;
        r = 1;
        for (int p = 1; p <= clog2(n); p++) begin
            for (int q = p - 1; q >= 0; q--) begin
                if (c == s) r = want_block ? (1 << p) : (1 << q);
                c++;
            end
        end
        return r;
    endfunction

    function automatic int partner(input int s, input int i, input int n);
        return i ^ stage_span(s, n, 1'b0);
    endfunction

    function automatic bit stage_desc(input int s, input int i, input int n);
        return (i & stage_span(s, n, 1'b1)) != 0;
    endfunction

endpackage

// File: rtl/sort_bitonic_pipe_cmp_swap.sv
// One compare-exchange cell; swaps only on strict disorder so ties
// stay in their lanes. Tags ride along with their keys.
module sort_cmp_swap #(
    parameter int W  = 8,
    parameter int TW = 3
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [TW-1:0] a_tag,
    input  logic [TW-1:0] b_tag,
    input  logic          dir,
    output logic [W-1:0]  lo,
    output logic [W-1:0]  hi,
    output logic [TW-1:0] lo_tag,
    output logic [TW-1:0] hi_tag
);

    logic swap;

    always_comb begin
        swap   = dir ? (a < b) : (a > b);
        lo     = swap ? b : a;
        hi     = swap ? a : b;
        lo_tag = swap ? b_tag : a_tag;
        hi_tag = swap ? a_tag : b_tag;
    end

endmodule

// File: rtl/sort_bitonic_pipe.sv
// Fully registered bitonic sorter: one vector per cycle, per-vector
// sort order, original-position tags, single global stall enable.
module sort_bitonic_pipe
    import sort_pkg::*;
#(
    parameter int N_ELEM = 8,
    parameter int W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_ELEM*W-1:0]             in_data,
    input  logic                            in_desc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_ELEM*W-1:0]             out_data,
    output logic [N_ELEM*clog2(N_ELEM)-1:0] out_idx,
    output logic                            busy
);

    localparam int L = clog2(N_ELEM);
    localparam int S = n_stages(N_ELEM);

    logic [N_ELEM-1:0][W-1:0] data_q   [S];
    logic [N_ELEM-1:0][W-1:0] data_d   [S];
    logic [N_ELEM-1:0][L-1:0] idx_q    [S];
    logic [N_ELEM-1:0][L-1:0] idx_d    [S];
    logic [S-1:0]             valid_q;
    logic [S-1:0]             valid_d;
    logic [S-1:0]             desc_q;
    logic [S-1:0]             desc_d;

    logic [N_ELEM-1:0][W-1:0] src_data [S];
    logic [N_ELEM-1:0][L-1:0] src_idx  [S];
    logic [S-1:0]             src_valid;
    logic [S-1:0]             src_desc;
    logic [N_ELEM-1:0][W-1:0] net_data [S];
    logic [N_ELEM-1:0][L-1:0] net_idx  [S];
    logic                     en;

    for (genvar s = 0; s < S; s++) begin : g_stage
        if (s == 0) begin : g_src
            assign src_data[s]  = in_data;
            assign src_valid[s] = in_valid;
            assign src_desc[s]  = in_desc;
            for (genvar i = 0; i < N_ELEM; i++) begin : g_tag
                assign src_idx[s][i] = L'(i);
            end
        end else begin : g_src
            assign src_data[s]  = data_q[s-1];
            assign src_idx[s]   = idx_q[s-1];
            assign src_valid[s] = valid_q[s-1];
            assign src_desc[s]  = desc_q[s-1];
        end

        for (genvar i = 0; i < N_ELEM; i++) begin : g_lane
            localparam int P = partner(s, i, N_ELEM);
            localparam bit D = stage_desc(s, i, N_ELEM);
            // The lower lane of each pair owns the comparator.
            if (P > i) begin : g_cmp
                sort_cmp_swap #(
                    .W  (W),
                    .TW (L)
                ) u_cmp (
                    .a      (src_data[s][i]),
                    .b      (src_data[s][P]),
                    .a_tag  (src_idx[s][i]),
                    .b_tag  (src_idx[s][P]),
                    .dir    (D ^ src_desc[s]),
                    .lo     (net_data[s][i]),
                    .hi     (net_data[s][P]),
                    .lo_tag (net_idx[s][i]),
                    .hi_tag (net_idx[s][P])
                );
            end
        end
    end

    always_comb begin
        en      = !valid_q[S-1] || out_ready;
        valid_d = valid_q;
        desc_d  = desc_q;
        data_d  = data_q;
        idx_d   = idx_q;
        if (en) begin
            valid_d = src_valid;
            desc_d  = src_desc;
            data_d  = net_data;
            idx_d   = net_idx;
        end
        if (rst) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        desc_q  <= desc_d;
        data_q  <= data_d;
        idx_q   <= idx_d;
    end

    assign in_ready  = en;
    assign out_valid = valid_q[S-1];
    assign out_data  = data_q[S-1];
    assign out_idx   = idx_q[S-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_sort_bitonic_pipe.sv
// Bench for sort_bitonic_pipe (N_ELEM=8, W=8): queue-based reference
// sorter checked every cycle plus literal expectations for key vectors.
module tb_sort_bitonic_pipe;

    localparam int N = 8;
    localparam int W = 8;
    localparam int S = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_desc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [23:0] out_idx;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int cycle  = 0;
    int stalls = 0;
    bit head_seen = 0;

    typedef struct {
        logic [63:0] d;
        logic [63:0] exp;
        int          acc;
        int          stl;
    } ent_t;

    ent_t mq[$];

    sort_bitonic_pipe #(.N_ELEM(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_sort(input logic [63:0] d,
                                             input bit desc);
        logic [7:0]  a [8];
        logic [7:0]  t;
        logic [63:0] r;
        for (int i = 0; i < 8; i++) a[i] = d[i*8 +: 8];
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    function automatic bit idx_ok(input logic [63:0] src,
                                  input logic [63:0] dat,
                                  input logic [23:0] idx);
        logic [7:0] seen;
        logic [2:0] k;
        bit ok;
        seen = '0;
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            k = idx[i*3 +: 3];
            if (src[k*8 +: 8] != dat[i*8 +: 8]) ok = 0;
            seen[k] = 1'b1;
        end
        return ok && (seen == 8'hFF);
    endfunction

    function automatic logic [63:0] rand_vec();
        bit [255:0]  used;
        logic [63:0] r;
        int v;
        used = '0;
        for (int i = 0; i < 8; i++) begin
            do v = $urandom_range(0, 255); while (used[v]);
            used[v] = 1'b1;
            r[i*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Compare process: every cycle while not in reset.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            head_seen = 0;
        end else begin
            chk(in_ready === (!out_valid || out_ready), "in_ready",
                64'(in_ready), 64'(!out_valid || out_ready));
            chk(busy === (mq.size() != 0), "busy",
                64'(busy), 64'(mq.size() != 0));
            if (out_valid) begin
                if (mq.size() == 0) begin
                    chk(0, "spurious_out", out_data, 64'h0);
                end else begin
                    chk(out_data === mq[0].exp, "out_data",
                        out_data, mq[0].exp);
                    chk(idx_ok(mq[0].d, out_data, out_idx), "out_idx",
                        64'(out_idx), mq[0].d);
                    if (!head_seen) begin
                        head_seen = 1;
                        if (mq[0].stl == stalls)
                            chk(cycle - mq[0].acc == S, "latency",
                                64'(cycle - mq[0].acc), 64'(S));
                    end
                    if (out_ready) begin
                        void'(mq.pop_front());
                        head_seen = 0;
                    end
                end
            end
            if (!(!out_valid || out_ready)) stalls++;
            if (in_valid && in_ready)
                mq.push_back('{in_data, ref_sort(in_data, in_desc),
                               cycle, stalls});
        end
    end

    task automatic send(input logic [63:0] d, input bit desc);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_desc  = desc;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        chk(ok, "send_accept", 64'(ok), 64'd1);
    endtask

    task automatic expect_out(input logic [63:0] exp, input int max_wait,
                              input bit use_idx, input logic [23:0] eidx,
                              input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < max_wait);
        chk(out_valid === 1'b1, {name, "_valid"}, 64'(out_valid), 64'd1);
        if (out_valid === 1'b1) begin
            chk(out_data === exp, name, out_data, exp);
            if (use_idx)
                chk(out_idx === eidx, {name, "_idx"},
                    64'(out_idx), 64'(eidx));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || mq.size() != 0) && n < 200);
        chk(!busy && mq.size() == 0, "drain", 64'(mq.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] rev_idx;
        rev_idx = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        chk(busy === 1'b0, "rst_busy", 64'(busy), 64'd0);
        chk(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reverse order, ascending.
        send(64'h0001020304050607, 1'b0);
        in_valid = 1'b0;
        expect_out(64'h0706050403020100, 20, 1'b1, rev_idx, "asc_rev");
        drain();

        // Descending then ascending back-to-back.
        send(64'h0706050403020100, 1'b1);
        send(64'h0706050403020100, 1'b0);
        in_valid = 1'b0;
        expect_out(64'h0001020304050607, 20, 1'b1, rev_idx, "desc_inc");
        expect_out(64'h0706050403020100, 1, 1'b0, '0, "asc_next");
        drain();

        // Streaming.
        for (int i = 0; i < 10; i++) send(rand_vec(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        drain();

        // Backpressure mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_vec(), 1'(i));
                in_valid = 1'b0;
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Extremes.
        send(64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(64'hFF00FF00FF00FF00, 1'b0);
        in_valid = 1'b0;
        expect_out(64'hFFFFFFFFFFFFFFFF, 20, 1'b0, '0, "all_ff");
        expect_out(64'hFFFFFFFF00000000, 1, 1'b0, '0, "alt_00_ff");
        drain();

        // Reset with three vectors in flight.
        send(rand_vec(), 1'b0);
        send(rand_vec(), 1'b1);
        send(rand_vec(), 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid === 1'b0, "midrst_out_valid", 64'(out_valid), 64'd0);
        chk(busy === 1'b0, "midrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        send(64'h1122334455667788, 1'b0);
        in_valid = 1'b0;
        expect_out(64'h8877665544332211, 20, 1'b0, '0, "post_rst");
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
